soc_top: RTL and testbench
==========================

SOC_TOP -- requirements
Module: soc_top

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (868 at defaults).
REQ-003 Parameter MEM_WORDS, default 16384, BRAM depth in 32-bit words (64 KiB).
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port uart_tx  output  1  UART serial transmit line, idle high.
REQ-007 Unified instruction/data memory SHALL be an instance named bram_mem holding array mem[0:MEM_WORDS-1] of 32-bit words, word-indexed by byte address bits [15:2], little-endian, hierarchically accessible for preload and inspection.

Function
REQ-008 CPU SHALL execute RV32I: LUI, AUIPC, JAL, JALR, branches, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP; FENCE, ECALL, EBREAK and undefined encodings SHALL act as NOP (PC+4).
REQ-009 Register file: 32x32, x0 reads zero and ignores writes; contents not reset.
REQ-010 CPU SHALL be a multi-cycle FSM: FETCH (drive PC to BRAM) -> FWAIT (1-cycle read latency) -> EXEC -> MEM (loads/stores only) -> LWAIT (loads only) -> back to FETCH.
REQ-011 Latency: ALU/branch/jump 3 cycles, store 4 cycles, load 5 cycles per instruction.
REQ-012 Memory map: 0x0000_0000-0x0000_FFFF BRAM; 0x1000_0000 UART data (write); 0x1000_0004 UART status (read, bit0 = busy, others 0); other addresses: writes ignored, reads return 0.
REQ-013 BRAM: one port, synchronous read with 1-cycle latency, per-byte write enables; SB writes one byte lane, SH two lanes selected by addr[1], SW all four; contents never cleared by reset.
REQ-014 Loads SHALL sign-extend (LB/LH) or zero-extend (LBU/LHU) the lane selected by addr[1:0]; misaligned halfword/word accesses SHALL ignore the offending low address bits.
REQ-015 Shifts use rs2/imm bits [4:0]; SLT/SLTI signed, SLTU/SLTIU unsigned; arithmetic wraps modulo 2^32.
REQ-016 JALR target = (rs1+imm) with bit0 cleared; JAL/JALR write PC+4 to rd.
REQ-017 UART: write to data register while not busy starts a frame: start bit 0, data bits 7:0 LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles; busy asserted from the cycle after the write until stop bit ends.
REQ-018 UART write while busy SHALL be dropped; software polls status.
REQ-019 uart_tx SHALL be driven from a register (glitch-free).

Reset
REQ-020 While rst=1: PC=0, FSM=FETCH, UART idle, busy=0, uart_tx=1, no memory writes issued.
REQ-021 First fetch from address 0 SHALL occur on the first rising edge after rst deasserts.
REQ-022 Reset asserted mid-instruction or mid-UART-frame SHALL abort it; uart_tx=1 on the cycle after the reset edge.

Verification
REQ-023 Hold rst 5 cycles -> uart_tx=1, mem unchanged, fetch begins at 0x0 after release.
REQ-024 Program computing 1+1, SW 2 to 0x1000 then SW 0xDEADBEEF to 0x1004 -> mem[1024]=2, mem[1025]=0xDEADBEEF within 200000 cycles.
REQ-025 SW 0x55 to 0x1000_0000 -> uart_tx low 868 cycles, then 1,0,1,0,1,0,1,0 at 868 cycles each, then high; status busy=1 throughout, 0 after.
REQ-026 SB 0x80 to 0x1009, then LB and LBU 0x1009 -> 0xFFFFFF80 and 0x00000080; mem[1026] = 0x00008000.
REQ-027 Loop of BNE counting 0..10 plus JAL/JALR call/return -> counter 10, return address = call PC+4, x0 remains 0.
REQ-028 Assert rst during UART frame -> uart_tx=1 next cycle, busy=0, PC restarts at 0.

Source files
------------

// File: rtl/soc_top.sv
// soc_top: multi-cycle RV32I core sharing one single-port BRAM for code and data,
// with a transmit-only UART at 0x1000_0000 (data) / 0x1000_0004 (status).

module soc_bram #(
    parameter int WORDS = 16384,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[idx];
    end
endmodule

module soc_top #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 115200,
    parameter int MEM_WORDS = 16384
) (
    input  logic clk,
    input  logic rst,
    output logic uart_tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW = $clog2(MEM_WORDS);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);

    // state | meaning
    // FETCH | PC drives the BRAM address
    // FWAIT | instruction word returns and is latched into ir
    // EXEC  | decode, ALU, branch/jump, register writeback
    // MEM   | load/store address, byte enables and UART write issued
    // LWAIT | load data returns, lane-aligned and written back
    typedef enum logic [2:0] {FETCH, FWAIT, EXEC, MEM, LWAIT} state_t;
    state_t state, state_nxt;

    logic [31:0] pc, pc_nxt, ir, maddr, maddr_nxt;
    logic [31:0] rf [0:31];
    logic        rf_we, uart_start, busy;
    logic [31:0] rf_wd, ram_wd, ram_rd, alu_b, alu_res, ld_word, ld_val;
    logic [3:0]  ram_we, be;
    logic [AW-1:0] ram_idx;
    logic        br_taken, is_ram, is_udata, is_ustat;
    logic [TW-1:0] timer;
    logic [3:0]  bit_cnt;
    logic [8:0]  shift;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'd0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign is_ram   = (maddr[31:16] == 16'd0);
    assign is_udata = (maddr[31:2] == 30'h0400_0000);
    assign is_ustat = (maddr[31:2] == 30'h0400_0001);

    soc_bram #(.WORDS(MEM_WORDS), .AW(AW)) bram_mem (
        .clk   (clk),
        .idx   (ram_idx),
        .we    (ram_we),
        .wdata (ram_wd),
        .rdata (ram_rd)
    );

    always_comb begin
        alu_b   = (opcode == 7'b0110011) ? rs2_v : imm_i;
        alu_res = 32'd0;
        case (f3)
            3'd0: alu_res = (opcode == 7'b0110011 && ir[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1: alu_res = rs1_v << alu_b[4:0];
            3'd2: alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'd3: alu_res = {31'd0, rs1_v < alu_b};
            3'd4: alu_res = rs1_v ^ alu_b;
            3'd5: alu_res = ir[30] ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'd6: alu_res = rs1_v | alu_b;
            default: alu_res = rs1_v & alu_b;
        endcase

        br_taken = 1'b0;
        case (f3)
            3'd0: br_taken = (rs1_v == rs2_v);
            3'd1: br_taken = (rs1_v != rs2_v);
            3'd4: br_taken = $signed(rs1_v) < $signed(rs2_v);
            3'd5: br_taken = $signed(rs1_v) >= $signed(rs2_v);
            3'd6: br_taken = rs1_v < rs2_v;
            3'd7: br_taken = rs1_v >= rs2_v;
            default: br_taken = 1'b0;
        endcase

        // store lanes: misaligned halfword/word addresses simply drop the low bits
        case (f3[1:0])
            2'd0:    begin be = 4'b0001 << maddr[1:0]; ram_wd = {4{rs2_v[7:0]}}; end
            2'd1:    begin be = maddr[1] ? 4'b1100 : 4'b0011; ram_wd = {2{rs2_v[15:0]}}; end
            default: begin be = 4'b1111; ram_wd = rs2_v; end
        endcase

        ld_word = is_ram ? ram_rd : (is_ustat ? {31'd0, busy} : 32'd0);
        case (f3)
            3'd0: ld_val = {{24{ld_word[{maddr[1:0], 3'b000} + 7]}}, ld_word[{maddr[1:0], 3'b000} +: 8]};
            3'd1: ld_val = maddr[1] ? {{16{ld_word[31]}}, ld_word[31:16]} : {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4: ld_val = {24'd0, ld_word[{maddr[1:0], 3'b000} +: 8]};
            3'd5: ld_val = maddr[1] ? {16'd0, ld_word[31:16]} : {16'd0, ld_word[15:0]};
            default: ld_val = ld_word;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        maddr_nxt  = maddr;
        rf_we      = 1'b0;
        rf_wd      = alu_res;
        ram_we     = 4'd0;
        ram_idx    = pc[AW+1:2];
        uart_start = 1'b0;
        case (state)
            FETCH: state_nxt = FWAIT;
            FWAIT: state_nxt = EXEC;
            EXEC: begin
                state_nxt = FETCH;
                pc_nxt    = pc + 32'd4;
                case (opcode)
                    7'b0110111: begin rf_we = 1'b1; rf_wd = imm_u; end
                    7'b0010111: begin rf_we = 1'b1; rf_wd = pc + imm_u; end
                    7'b1101111: begin rf_we = 1'b1; rf_wd = pc + 32'd4; pc_nxt = pc + imm_j; end
                    7'b1100111: if (f3 == 3'd0) begin
                        rf_we  = 1'b1;
                        rf_wd  = pc + 32'd4;
                        pc_nxt = (rs1_v + imm_i) & ~32'd1;
                    end
                    7'b1100011: if (br_taken) pc_nxt = pc + imm_b;
                    7'b0000011: if (f3 != 3'd3 && f3 < 3'd6) begin
                        maddr_nxt = rs1_v + imm_i;
                        state_nxt = MEM;
                    end
                    7'b0100011: if (f3 < 3'd3) begin
                        maddr_nxt = rs1_v + imm_s;
                        state_nxt = MEM;
                    end
                    7'b0010011: rf_we = (f3 != 3'd1 && f3 != 3'd5) || f7 == 7'd0 ||
                                        (f3 == 3'd5 && f7 == 7'h20);
                    7'b0110011: rf_we = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    default: ;
                endcase
            end
            MEM: begin
                ram_idx = maddr[AW+1:2];
                if (ir[5]) begin
                    state_nxt  = FETCH;
                    ram_we     = (is_ram && !rst) ? be : 4'd0;
                    uart_start = is_udata && !busy;
                end else begin
                    state_nxt = LWAIT;
                end
            end
            LWAIT: begin
                state_nxt = FETCH;
                rf_we     = 1'b1;
                rf_wd     = ld_val;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        maddr <= maddr_nxt;
        if (state == FWAIT) ir <= ram_rd;
        if (rf_we && rd != 5'd0 && !rst) rf[rd] <= rf_wd;
    end

    // shift holds the remaining data bits plus the stop bit; timer counts down each bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            uart_tx <= 1'b1;
            timer   <= '0;
            bit_cnt <= 4'd0;
            shift   <= 9'd0;
        end else if (uart_start) begin
            busy    <= 1'b1;
            uart_tx <= 1'b0;
            shift   <= {1'b1, rs2_v[7:0]};
            bit_cnt <= 4'd9;
            timer   <= TW'(CLKS_PER_BIT - 1);
        end else if (busy) begin
            if (timer == '0) begin
                if (bit_cnt == 4'd0) begin
                    busy <= 1'b0;
                end else begin
                    uart_tx <= shift[0];
                    shift   <= {1'b0, shift[8:1]};
                    bit_cnt <= bit_cnt - 4'd1;
                    timer   <= TW'(CLKS_PER_BIT - 1);
                end
            end else begin
                timer <= timer - TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top: directed programs preloaded into BRAM; results checked against
// hand-computed register, memory, UART waveform and cycle-count values.

module tb_soc_top;
    localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011;
    localparam int BIT = 868;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pos = 0;
    int fetch_at [int];
    logic [31:0] prog_a [32];
    logic [31:0] prog_b [10];
    logic [9:0]  frame;

    soc_top dut (.clk(clk), .rst(rst), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (32'(dut.state) == 32'd0 && !fetch_at.exists(int'(dut.pc)))
            fetch_at[int'(dut.pc)] = cyc;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic wait_fall(input string tag);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) break;
        end
        check_val(tag, {31'd0, uart_tx}, 32'd0);
        pos = 0;
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] target);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dut.pc == target) break;
        end
        check_val(tag, dut.pc, target);
    endtask

    function automatic int fetch_of(input int a);
        return fetch_at.exists(a) ? fetch_at[a] : -1000;
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) prog_a[i] = 32'h0000_0013;
        prog_a[0]  = enc_i(1, 0, 0, 1, OPIMM);            // x1 = 1
        prog_a[1]  = enc_i(1, 1, 0, 2, OPIMM);            // x2 = 2
        prog_a[2]  = enc_u(32'h1, 3, 7'b0110111);         // x3 = 0x1000
        prog_a[3]  = enc_s(0, 2, 3, 2);                   // sw x2,0(x3)
        prog_a[4]  = enc_u(32'hDEADC, 4, 7'b0110111);
        prog_a[5]  = enc_i(-273, 4, 0, 4, OPIMM);         // x4 = 0xDEADBEEF
        prog_a[6]  = enc_s(4, 4, 3, 2);                   // sw x4,4(x3)
        prog_a[7]  = enc_i(32'h80, 0, 0, 5, OPIMM);
        prog_a[8]  = enc_s(9, 5, 3, 0);                   // sb x5,9(x3)
        prog_a[9]  = enc_i(9, 3, 0, 6, LOAD);             // lb
        prog_a[10] = enc_i(9, 3, 4, 7, LOAD);             // lbu
        prog_a[11] = enc_i(0, 0, 0, 8, OPIMM);
        prog_a[12] = enc_i(10, 0, 0, 9, OPIMM);
        prog_a[13] = enc_i(1, 8, 0, 8, OPIMM);            // loop: x8++
        prog_a[14] = enc_b(-4, 9, 8, 1);                  // bne x8,x9,loop
        prog_a[15] = enc_j(32'h44, 1);                    // jal x1,0x80
        prog_a[16] = enc_i(3, 0, 0, 22, OPIMM);
        prog_a[17] = enc_i(5, 0, 0, 0, OPIMM);            // write attempt to x0
        prog_a[18] = enc_r(0, 0, 0, 0, 22);               // x22 = x0 + x0
        prog_a[19] = enc_r(32'h20, 9, 0, 0, 12);          // sub
        prog_a[20] = enc_i(32'h401, 12, 5, 13, OPIMM);    // srai 1
        prog_a[21] = enc_r(0, 9, 12, 2, 14);              // slt
        prog_a[22] = enc_r(0, 9, 12, 3, 15);              // sltu
        prog_a[23] = enc_i(28, 12, 5, 16, OPIMM);         // srli 28
        prog_a[24] = enc_u(32'h1, 17, 7'b0010111);        // auipc
        prog_a[25] = enc_i(8, 3, 1, 18, LOAD);            // lh 0x1008
        prog_a[26] = enc_i(4, 3, 5, 19, LOAD);            // lhu 0x1004
        prog_a[27] = enc_s(14, 5, 3, 1);                  // sh x5,0x100E
        prog_a[28] = 32'h0000_0073;                       // ecall as nop
        prog_a[29] = enc_j(0, 0);                         // halt at 0x74
        prog_a[30] = enc_i(0, 1, 0, 10, OPIMM);           // 0x78 unused
        prog_a[31] = 32'h0000_0013;

        prog_b[0] = enc_u(32'h10000, 1, 7'b0110111);
        prog_b[1] = enc_i(32'h55, 0, 0, 2, OPIMM);
        prog_b[2] = enc_s(0, 2, 1, 2);                    // start frame
        prog_b[3] = enc_i(4, 1, 2, 3, LOAD);              // status
        prog_b[4] = enc_i(32'h41, 0, 0, 5, OPIMM);
        prog_b[5] = enc_s(0, 5, 1, 2);                    // dropped while busy
        prog_b[6] = enc_i(4, 1, 2, 4, LOAD);              // poll
        prog_b[7] = enc_b(-4, 0, 4, 1);
        prog_b[8] = enc_i(4, 1, 2, 6, LOAD);
        prog_b[9] = enc_j(0, 0);                          // halt at 0x24

        for (int i = 0; i < 16384; i++) dut.bram_mem.mem[i] = 32'd0;
        for (int i = 0; i < 30; i++) dut.bram_mem.mem[i] = prog_a[i];
        dut.bram_mem.mem[32] = enc_i(0, 1, 0, 10, OPIMM); // 0x80: x10 = ra
        dut.bram_mem.mem[33] = enc_i(1, 1, 0, 0, 7'b1100111); // jalr x0,1(x1)

        ncyc(5);
        check_val("rst_tx", {31'd0, uart_tx}, 32'd1);
        check_val("rst_pc", dut.pc, 32'd0);
        check_val("rst_state", 32'(dut.state), 32'd0);
        check_val("rst_mem0", dut.bram_mem.mem[0], prog_a[0]);
        check_val("rst_mem1024", dut.bram_mem.mem[1024], 32'd0);
        rst = 1'b0;
        fetch_at.delete();
        ncyc(1);
        check_val("rel_fwait", 32'(dut.state), 32'd1);
        check_val("rel_pc0", dut.pc, 32'd0);
        ncyc(2);
        check_val("alu_lat_pc", dut.pc, 32'd4);

        wait_pc("haltA", 32'h74);
        ncyc(6);
        check_val("mem1024", dut.bram_mem.mem[1024], 32'd2);
        check_val("mem1025", dut.bram_mem.mem[1025], 32'hDEADBEEF);
        check_val("mem1026", dut.bram_mem.mem[1026], 32'h0000_8000);
        check_val("mem1027_sh", dut.bram_mem.mem[1027], 32'h0080_0000);
        check_val("lb", dut.rf[6], 32'hFFFF_FF80);
        check_val("lbu", dut.rf[7], 32'h0000_0080);
        check_val("loop_cnt", dut.rf[8], 32'd10);
        check_val("ra", dut.rf[1], 32'h40);
        check_val("ra_copy", dut.rf[10], 32'h40);
        check_val("x0_zero", dut.rf[22], 32'd0);
        check_val("sub", dut.rf[12], 32'hFFFF_FFF6);
        check_val("srai", dut.rf[13], 32'hFFFF_FFFB);
        check_val("slt", dut.rf[14], 32'd1);
        check_val("sltu", dut.rf[15], 32'd0);
        check_val("srli", dut.rf[16], 32'hF);
        check_val("auipc", dut.rf[17], 32'h1060);
        check_val("lh", dut.rf[18], 32'hFFFF_8000);
        check_val("lhu", dut.rf[19], 32'h0000_BEEF);
        check_val("lat_alu_store", 32'(fetch_of(32'h10) - fetch_of(32'h04)), 32'd10);
        check_val("lat_mix_load", 32'(fetch_of(32'h2C) - fetch_of(32'h10)), 32'd27);
        check_val("lat_loop", 32'(fetch_of(32'h3C) - fetch_of(32'h2C)), 32'd66);
        check_val("lat_jal", 32'(fetch_of(32'h80) - fetch_of(32'h3C)), 32'd3);

        rst = 1'b1;
        ncyc(2);
        for (int i = 0; i < 10; i++) dut.bram_mem.mem[i] = prog_b[i];
        ncyc(1);
        rst = 1'b0;
        wait_fall("fall1");
        frame = {1'b1, 8'h55, 1'b0};
        goto(BIT / 2);
        check_val("bit0", {31'd0, uart_tx}, {31'd0, frame[0]});
        check_val("busy0", {31'd0, dut.busy}, 32'd1);
        goto(BIT - 1);
        check_val("start_last", {31'd0, uart_tx}, 32'd0);
        goto(BIT);
        check_val("data0_first", {31'd0, uart_tx}, 32'd1);
        for (int k = 1; k < 10; k++) begin
            goto(k * BIT + BIT / 2);
            check_val($sformatf("bit%0d", k), {31'd0, uart_tx}, {31'd0, frame[k]});
            check_val($sformatf("busy%0d", k), {31'd0, dut.busy}, 32'd1);
        end
        goto(10 * BIT - 1);
        check_val("stop_last_busy", {31'd0, dut.busy}, 32'd1);
        goto(10 * BIT);
        check_val("done_busy", {31'd0, dut.busy}, 32'd0);
        check_val("done_tx", {31'd0, uart_tx}, 32'd1);
        goto(12 * BIT);
        check_val("no_second_frame", {31'd0, uart_tx}, 32'd1);
        wait_pc("haltB", 32'h24);
        ncyc(6);
        check_val("status_busy", dut.rf[3], 32'd1);
        check_val("status_idle", dut.rf[6], 32'd0);

        rst = 1'b1;
        ncyc(2);
        rst = 1'b0;
        wait_fall("fall2");
        goto(2 * BIT + BIT / 2);
        check_val("mid_frame_tx", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        ncyc(1);
        check_val("abort_tx", {31'd0, uart_tx}, 32'd1);
        check_val("abort_busy", {31'd0, dut.busy}, 32'd0);
        check_val("abort_pc", dut.pc, 32'd0);
        ncyc(1);
        rst = 1'b0;
        ncyc(1);
        check_val("restart_fwait", 32'(dut.state), 32'd1);
        check_val("restart_pc", dut.pc, 32'd0);
        wait_fall("restart_fall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
